// File: rtl/sdcram_pkg.sv
// Shared constants and state encoding for the SD sector buffer.
package sdcram_pkg;
  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_WORDS = 128;
  localparam int TAG_W = 32;
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_DATA,
    WB_WAIT,
    FILL_REQ,
    FILL_DATA,
    RESP
  } state_t;
endpackage

// File: rtl/sdcram_sector_ram.sv
// 128x32 single-port RAM, byte write enables, registered read.
module sdcram_sector_ram
  import sdcram_pkg::*;
(
  input  logic        clk,
  input  logic [6:0]  addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] mem [SECTOR_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/sdcram_sector_buffer.sv
// Single-sector write-back buffer in front of an SD block driver.
// Word accesses hit in the buffer or trigger write-back and refill.
module sdcram_sector_buffer
  import sdcram_pkg::*;
#(
  parameter int SECTOR_BYTES = 512,
  parameter bit INIT_BUSY = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [40:0] sdcram_addr,
  input  logic        sdcram_ren,
  input  logic [3:0]  sdcram_wen,
  input  logic [31:0] sdcram_wdata,
  output logic [31:0] sdcram_rdata,
  output logic        sdcram_busy,
  input  logic        sd_ready,
  output logic [31:0] blk_addr,
  output logic        blk_rd_req,
  output logic        blk_wr_req,
  input  logic        blk_done,
  input  logic [7:0]  blk_rdata,
  input  logic        blk_rvalid,
  output logic [7:0]  blk_wdata,
  input  logic        blk_wready
);
  // only the 512-byte geometry is supported
  localparam int BYTES =
    (SECTOR_BYTES == sdcram_pkg::SECTOR_BYTES) ?
    SECTOR_BYTES : sdcram_pkg::SECTOR_BYTES;
  localparam logic [8:0] LAST = 9'(BYTES - 1);

  state_t state, state_nx;
  logic [TAG_W-1:0] tag, req_tag;
  logic valid, dirty, ready_q, req_wr;
  logic [6:0] req_word;
  logic [3:0] req_wen;
  logic [31:0] req_wdata;
  logic [8:0] cnt, wb_next;
  logic [6:0] ram_addr;
  logic [3:0] ram_we;
  logic [31:0] ram_wdata, ram_q;
  logic accept, hit, unused_bits;

  assign unused_bits = ^sdcram_addr[1:0];
  assign sdcram_busy = (state != IDLE) ||
                       (INIT_BUSY && !ready_q);
  assign accept = !sdcram_busy &&
                  (sdcram_ren || (|sdcram_wen));
  assign hit = valid && (tag == req_tag);
  assign wb_next = cnt + {8'd0, blk_wready};
  assign blk_wr_req = state inside {WB_REQ, WB_DATA, WB_WAIT};
  assign blk_rd_req = state inside {FILL_REQ, FILL_DATA};
  assign blk_wdata = (state == WB_DATA) ?
                     ram_q[{cnt[1:0], 3'b000} +: 8] : 8'd0;

  sdcram_sector_ram u_ram (
    .clk  (CLK),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (accept) state_nx = LOOKUP;
      LOOKUP:    state_nx = hit ? RESP :
                            dirty ? WB_REQ : FILL_REQ;
      WB_REQ:    state_nx = WB_DATA;
      WB_DATA:   if (blk_wready && cnt == LAST)
                   state_nx = WB_WAIT;
      WB_WAIT:   if (blk_done) state_nx = FILL_REQ;
      FILL_REQ:  state_nx = FILL_DATA;
      FILL_DATA: if (blk_done) state_nx = RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // RAM port: prefetch next write-back word, else the request word
  always_comb begin
    ram_addr = req_word;
    ram_we = 4'd0;
    ram_wdata = {4{blk_rdata}};
    unique case (state)
      WB_REQ:  ram_addr = cnt[8:2];
      WB_DATA: ram_addr = wb_next[8:2];
      FILL_DATA:
        if (blk_rvalid) begin
          ram_addr = cnt[8:2];
          ram_we = 4'b0001 << cnt[1:0];
        end
      RESP:
        if (req_wr) begin
          ram_we = req_wen;
          ram_wdata = req_wdata;
        end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
      dirty <= 1'b0;
      ready_q <= 1'b0;
      tag <= '0;
      blk_addr <= '0;
      cnt <= '0;
      sdcram_rdata <= '0;
      req_tag <= '0;
      req_word <= '0;
      req_wen <= '0;
      req_wr <= 1'b0;
      req_wdata <= '0;
    end else begin
      ready_q <= sd_ready;
      if (accept) begin
        req_tag <= sdcram_addr[40:9];
        req_word <= sdcram_addr[8:2];
        req_wen <= sdcram_wen;
        req_wr <= |sdcram_wen;
        req_wdata <= sdcram_wdata;
      end
      unique case (state)
        LOOKUP: begin
          cnt <= '0;
          if (!hit) blk_addr <= dirty ? tag : req_tag;
        end
        WB_DATA: if (blk_wready) cnt <= wb_next;
        WB_WAIT:
          if (blk_done) begin
            dirty <= 1'b0;
            cnt <= '0;
            blk_addr <= req_tag;
          end
        FILL_REQ: valid <= 1'b0;
        FILL_DATA: begin
          if (blk_rvalid) cnt <= cnt + 9'd1;
          if (blk_done) begin
            valid <= 1'b1;
            tag <= req_tag;
          end
        end
        RESP:
          if (req_wr) dirty <= 1'b1;
          else sdcram_rdata <= ram_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdcram_sector_buffer.sv
// Randomized bench: SD card image plus one-sector buffer model.
module tb_sdcram_sector_buffer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [40:0] sdcram_addr = '0;
  logic sdcram_ren = 1'b0;
  logic [3:0] sdcram_wen = '0;
  logic [31:0] sdcram_wdata = '0;
  logic [31:0] sdcram_rdata;
  logic sdcram_busy;
  logic sd_ready = 1'b1;
  logic [31:0] blk_addr;
  logic blk_rd_req, blk_wr_req;
  logic blk_done = 1'b0;
  logic [7:0] blk_rdata = '0;
  logic blk_rvalid = 1'b0;
  logic [7:0] blk_wdata;
  logic blk_wready = 1'b0;

  int vectors = 0;
  int errors = 0;

  logic [7:0] card [longint];
  logic [7:0] buf_m [512];
  longint m_sec = 0;
  bit m_valid = 0;
  bit m_dirty = 0;
  logic [31:0] last_rd = '0;
  longint pool [4] = '{0, 1, 32'hABCD1234, 32'hFFFFFFFF};

  sdcram_sector_buffer dut (
    .CLK(CLK), .RST(RST),
    .sdcram_addr(sdcram_addr), .sdcram_ren(sdcram_ren),
    .sdcram_wen(sdcram_wen), .sdcram_wdata(sdcram_wdata),
    .sdcram_rdata(sdcram_rdata), .sdcram_busy(sdcram_busy),
    .sd_ready(sd_ready), .blk_addr(blk_addr),
    .blk_rd_req(blk_rd_req), .blk_wr_req(blk_wr_req),
    .blk_done(blk_done), .blk_rdata(blk_rdata),
    .blk_rvalid(blk_rvalid), .blk_wdata(blk_wdata),
    .blk_wready(blk_wready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] card_rd(input longint a);
    if (card.exists(a)) return card[a];
    return 8'(a + (a >> 9) * 7);
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_busy", sdcram_busy, 1);
    check("rst_rd_req", blk_rd_req, 0);
    check("rst_wr_req", blk_wr_req, 0);
    check("rst_blk_addr", blk_addr, 0);
    check("rst_wdata", blk_wdata, 0);
    check("rst_rdata", sdcram_rdata, 0);
    RST = 1'b0;
    m_valid = 0;
    m_dirty = 0;
    last_rd = '0;
  endtask

  task automatic access(input logic [40:0] a, input bit ren,
                        input logic [3:0] wen,
                        input logic [31:0] wd,
                        input int rst_at = -1,
                        input bit poke = 0);
    longint sec, old;
    int w, guard, busy_n, nw, nr, dly, bad;
    bit wr, exp_hit, exp_wb, wr_seen, rd_seen, aborted;
    logic [31:0] exp_rd;
    sec = longint'(a[40:9]);
    w = int'(a[8:2]);
    wr = (wen != 0);
    exp_hit = m_valid && m_sec == sec;
    exp_wb = !exp_hit && m_dirty;
    old = m_sec;
    guard = 0;
    busy_n = 0;
    nw = 0;
    nr = 0;
    dly = 0;
    bad = 0;
    wr_seen = 0;
    rd_seen = 0;
    aborted = 0;
    while (sdcram_busy && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("idle_before", sdcram_busy, 0);
    sdcram_addr = a;
    sdcram_ren = ren;
    sdcram_wen = wen;
    sdcram_wdata = wd;
    @(negedge CLK);
    sdcram_addr = 41'($urandom);
    guard = 0;
    while (sdcram_busy && guard < 5000) begin
      busy_n++;
      sdcram_ren = 0;
      sdcram_wen = 0;
      blk_done = 0;
      blk_rvalid = 0;
      blk_wready = 0;
      if (poke && busy_n == 3) begin
        sdcram_ren = 1;
        sdcram_wen = 4'hF;
        sdcram_addr = 41'h0;
      end
      if (blk_wr_req) begin
        if (!wr_seen) begin
          wr_seen = 1;
          dly = $urandom_range(0, 3);
          check("wb_addr", blk_addr, old);
        end else if (nw < 512) begin
          blk_wready = $urandom_range(0, 7) != 0;
          if (blk_wready) begin
            if (blk_wdata !== buf_m[nw]) bad++;
            card[old*512 + nw] = blk_wdata;
            nw++;
          end
        end else if (dly == 0) blk_done = 1;
        else dly--;
      end else if (blk_rd_req) begin
        if (!rd_seen) begin
          rd_seen = 1;
          dly = $urandom_range(0, 3);
          check("fill_addr", blk_addr, sec);
        end else if (nr < 512) begin
          if (nr == rst_at) begin
            RST = 1;
            @(negedge CLK);
            check("rst_drops_rd_req", blk_rd_req, 0);
            check("rst_mid_busy", sdcram_busy, 1);
            RST = 0;
            aborted = 1;
            break;
          end
          blk_rvalid = $urandom_range(0, 7) != 0;
          if (blk_rvalid) begin
            blk_rdata = card_rd(sec*512 + nr);
            nr++;
          end
        end else if (dly == 0) blk_done = 1;
        else dly--;
      end
      @(negedge CLK);
      guard++;
    end
    sdcram_ren = 0;
    sdcram_wen = 0;
    blk_done = 0;
    blk_rvalid = 0;
    blk_wready = 0;
    check("timeout", guard >= 5000, 0);
    if (aborted) begin
      m_valid = 0;
      m_dirty = 0;
      last_rd = '0;
      check("rst_mid_rdata", sdcram_rdata, 0);
      return;
    end
    check("wb_issued", wr_seen, exp_wb);
    check("fill_issued", rd_seen, !exp_hit);
    if (exp_wb) check("wb_bytes_bad", bad, 0);
    if (exp_hit) check("hit_busy_cycles", busy_n, 2);
    if (!exp_hit) begin
      for (int b = 0; b < 512; b++)
        buf_m[b] = card_rd(sec*512 + b);
      m_sec = sec;
      m_valid = 1;
      m_dirty = 0;
    end
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (wen[i]) buf_m[w*4 + i] = wd[8*i +: 8];
      m_dirty = 1;
    end else begin
      exp_rd = {buf_m[w*4+3], buf_m[w*4+2],
                buf_m[w*4+1], buf_m[w*4]};
      last_rd = exp_rd;
    end
    check("rdata", sdcram_rdata, last_rd);
    if (poke) begin
      @(negedge CLK);
      check("busy_req_ignored", sdcram_busy, 0);
    end
  endtask

  initial begin
    bit req_seen;
    do_reset();
    access(41'h000, 1, 4'h0, 0);
    check("first_read", sdcram_rdata, 32'h03020100);
    access(41'h004, 1, 4'h0, 0);
    check("hit_read", sdcram_rdata, 32'h07060504);
    access(41'h008, 0, 4'h3, 32'hDEADBEEF);
    access(41'h008, 1, 4'h0, 0);
    check("merge_read", sdcram_rdata, 32'h0B0ABEEF);
    access(41'h200, 1, 4'h0, 0);
    check("wb_byte8", card[8], 8'hEF);
    check("wb_byte9", card[9], 8'hBE);
    access(41'h210, 1, 4'hF, 32'h12345678);
    access(41'h400, 1, 4'h0, 0, -1, 1);
    access(41'h213, 1, 4'h0, 0);
    check("ren_wen_write", sdcram_rdata, 32'h12345678);

    sd_ready = 0;
    @(negedge CLK);
    @(negedge CLK);
    sdcram_ren = 1;
    @(negedge CLK);
    sdcram_ren = 0;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (blk_rd_req || blk_wr_req || !sdcram_busy)
        req_seen = 1;
      @(negedge CLK);
    end
    check("not_ready_quiet", req_seen, 0);
    sd_ready = 1;
    @(negedge CLK);
    @(negedge CLK);
    check("ready_idle", sdcram_busy, 0);

    access(41'h40C, 0, 4'h5, 32'hA5A5A5A5);
    access(41'h600, 1, 4'h0, 0, 100);
    access(41'h400, 1, 4'h0, 0);
    access(41'h600, 1, 4'h0, 0);

    for (int i = 0; i < 40; i++) begin
      longint s;
      logic [40:0] a;
      logic [3:0] wen;
      bit ren;
      if (m_valid && $urandom_range(0, 1) == 0) s = m_sec;
      else s = pool[$urandom_range(0, 3)];
      a = {s[31:0], 7'($urandom_range(0, 127)),
           2'($urandom_range(0, 3))};
      wen = $urandom_range(0, 1) ?
            4'($urandom_range(1, 15)) : 4'd0;
      ren = (wen == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      access(a, ren, wen, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule

// File: doc/sdcram_sector_buffer.md
SDCRAM_SECTOR_BUFFER -- requirements
Module: sdcram_sector_buffer

Interface
REQ-001 SHALL have parameter SECTOR_BYTES, default 512, bytes per SD sector (fixed; other values unsupported).
REQ-002 SHALL have parameter INIT_BUSY, default 1, meaning busy is held high until sd_ready rises.
REQ-003 SHALL have port CLK, input, 1, the single clock.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sdcram_addr, input, 41, byte address of the access.
REQ-006 SHALL have port sdcram_ren, input, 1, one-cycle read request.
REQ-007 SHALL have port sdcram_wen, input, 4, one-cycle write request with byte enables (lane n = bits 8n+7:8n).
REQ-008 SHALL have port sdcram_wdata, input, 32, write data.
REQ-009 SHALL have port sdcram_rdata, output, 32, read data.
REQ-010 SHALL have port sdcram_busy, output, 1, high while a request is in flight or the buffer is not ready.
REQ-011 SHALL have port sd_ready, input, 1, SD block driver initialised.
REQ-012 SHALL have port blk_addr, output, 32, sector number for the block driver.
REQ-013 SHALL have ports blk_rd_req and blk_wr_req, output, 1 each, level requests held until blk_done.
REQ-014 SHALL have port blk_done, input, 1, one-cycle completion pulse from the block driver.
REQ-015 SHALL have ports blk_rdata (input, 8) and blk_rvalid (input, 1), the read byte stream.
REQ-016 SHALL have ports blk_wdata (output, 8) and blk_wready (input, 1), the write byte stream; a byte is consumed in each cycle blk_wready is high.

Function
REQ-017 SHALL hold one 512-byte sector (128 x 32-bit words) with tag = addr[40:9], a valid bit and a dirty bit.
REQ-018 SHALL accept a request only in IDLE with sdcram_busy low; requests made while busy is high SHALL be ignored.
REQ-019 SHALL treat a request with both ren and any wen bit high as a write and ignore the ren.
REQ-020 SHALL raise busy in the cycle after acceptance and keep it high until the response is complete.
REQ-021 SHALL have states IDLE, LOOKUP, WB_REQ, WB_DATA, WB_WAIT, FILL_REQ, FILL_DATA, RESP.
REQ-022 SHALL treat a LOOKUP with valid and matching tag as a hit and go to RESP, so busy is high for exactly 2 cycles.
REQ-023 SHALL handle a miss as follows: if dirty, go to WB_REQ; otherwise go to FILL_REQ.
REQ-024 SHALL in WB_REQ drive blk_addr = old tag and assert blk_wr_req.
REQ-025 SHALL in WB_DATA stream bytes 0..511 in order, byte b = word b[8:2], lane b[1:0].
REQ-026 SHALL after byte 511 wait in WB_WAIT for blk_done, then clear dirty and go to FILL_REQ.
REQ-027 SHALL in FILL_REQ drive blk_addr = new tag and assert blk_rd_req.
REQ-028 SHALL in FILL_DATA write each blk_rvalid byte to the next byte position, using the same mapping as write-back.
REQ-029 SHALL on blk_done in FILL_DATA set valid, load the tag and go to RESP; more or fewer than 512 bytes is a driver error with undefined contents.
REQ-030 SHALL in RESP load rdata with the addressed word (read) or merge wdata under the byte enables and set dirty (write), then return to IDLE with busy low.
REQ-031 SHALL leave sdcram_rdata unchanged after writes and hold it until the next read completes.
REQ-032 SHALL keep sdcram_busy high while sd_ready is low (INIT_BUSY=1), with no block request issued.
REQ-033 SHALL ignore addr[1:0]; accesses are word-aligned.

Reset
REQ-034 SHALL on RST drive state IDLE, valid 0, dirty 0 (unwritten data discarded), busy 1 until sd_ready, rdata 0, blk_rd_req/blk_wr_req 0, blk_addr 0, blk_wdata 0, and byte counter 0.
REQ-035 SHALL apply RST mid-transfer by dropping the block requests in the next cycle, without waiting for blk_done.

Structure
REQ-036 SHALL place SECTOR_BYTES, SECTOR_WORDS=128, the tag width (32) and the state encoding in shared package sdcram_pkg.
REQ-037 SHALL implement storage as one sub-module sdcram_sector_ram: a 128x32 single-port RAM with 4-bit byte-write enable and 1-cycle registered read.

Verification
REQ-038 SHALL cover this scenario: after reset, sd_ready=1, read 0x000 -> blk_rd_req with blk_addr=0, 512 bytes 0x00..0xFF repeating, then rdata=0x03020100.
REQ-039 SHALL cover this scenario: read 0x004 directly after -> hit, no block request, busy high 2 cycles, rdata=0x07060504.
REQ-040 SHALL cover this scenario: write 0xDEADBEEF at 0x008 with wen=0b0011, then read 0x008 -> rdata=0x0B0ABEEF, dirty=1.
REQ-041 SHALL cover this scenario: read 0x200 -> write-back of sector 0 first (bytes 8,9 = 0xEF,0xBE), then fill of sector 1; blk_addr 0 then 1.
REQ-042 SHALL cover this scenario: ren together with wen=0xF -> treated as a write only; request during busy -> ignored; sd_ready=0 -> busy stays 1 with no blk_*_req.
REQ-043 SHALL cover this scenario: RST asserted at byte 100 of a fill -> blk_rd_req low in the next cycle, valid=0, and the next read re-fetches the sector.
